// File: rtl/uart_rx.sv
// 8x-oversampling UART receiver (8N1, LSB first) driven by the baud generator's bclk_8.
// Presents each received byte with a valid/read handshake and sticky framing/overrun flags.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int OSR       = 8,
  parameter int MID       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bclk_8,
  input  logic                 rx,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);
  localparam logic [TW-1:0] T_MID  = TW'(MID - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic                 bclk_8_q;
  logic                 tick;
  logic [2:0]           state;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 done;
  logic                 rd_ok;

  // Input stage: rx synchroniser (preset to idle) and bclk_8 rising-edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      bclk_8_q <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      bclk_8_q <= bclk_8;
    end
  end

  assign tick  = bclk_8 & ~bclk_8_q;
  assign done  = (state == STOP) && tick && (tcnt == T_LAST);
  assign rd_ok = rd & data_valid;
  assign busy  = (state != IDLE);

  // Frame sequencing: start detect at clk resolution, all bit timing on tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            tcnt  <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tcnt == T_MID) begin
              tcnt  <= '0;
              bcnt  <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tcnt == T_LAST) begin
              tcnt <= '0;
              if (bcnt == B_LAST) state <= STOP;
              else                bcnt  <= bcnt + BW'(1);
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tcnt == T_LAST) begin
              tcnt  <= '0;
              state <= rx_s ? IDLE : WAIT_IDLE;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath shift register; every bit is rewritten before it is ever presented
  always_ff @(posedge clk) begin
    if (state == DATA && tick && tcnt == T_LAST)
      shreg <= {rx_s, shreg[DATA_BITS-1:1]};
  end

  // Output stage: frame completion takes priority over a simultaneous read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      data_out   <= shreg;
      data_valid <= 1'b1;
      overrun    <= rd_ok ? 1'b0 : (overrun | data_valid);
      frame_err  <= (rd_ok ? 1'b0 : frame_err) | ~rx_s;
    end else if (rd_ok) begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one tick every 4 clk, so one bit lasts 32 clk.
module tb_uart_rx;

  localparam int BIT_CLKS = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       bclk_8;
  logic       rx;
  logic       rd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic busy_mid;

  uart_rx #(.DATA_BITS(8), .OSR(8), .MID(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bclk_8     (bclk_8),
    .rx         (rx),
    .rd         (rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    bclk_8 = 1'b0;
    forever begin
      repeat (2) @(negedge clk);
      bclk_8 = ~bclk_8;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT_CLKS / 2);
      if (i == 3) busy_mid = busy;
      wait_clks(BIT_CLKS / 2);
    end
    rx = stop;
    wait_clks(BIT_CLKS);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    wait_clks(1);
    rd = 1'b0;
    wait_clks(1);
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    rd  = 1'b0;
    busy_mid = 1'b0;
    wait_clks(5);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;

    // idle line for 200 ticks
    for (int i = 0; i < 10; i++) begin
      wait_clks(80);
      check("idle_busy", busy, 0);
    end
    check("idle_valid", data_valid, 0);
    check("idle_frame_err", frame_err, 0);
    check("idle_overrun", overrun, 0);
    check("idle_data_out", data_out, 8'h00);

    // clean frame 0xA5
    send_frame(8'hA5, 1'b1);
    check("a5_busy_mid", busy_mid, 1);
    check("a5_data_out", data_out, 8'hA5);
    check("a5_valid", data_valid, 1);
    check("a5_frame_err", frame_err, 0);
    check("a5_overrun", overrun, 0);
    pulse_rd();
    check("a5_rd_valid", data_valid, 0);
    check("a5_rd_data_held", data_out, 8'hA5);

    // two-tick low glitch while idle
    wait_clks(BIT_CLKS);
    rx = 1'b0;
    wait_clks(4);
    check("glitch_busy_start", busy, 1);
    wait_clks(4);
    rx = 1'b1;
    wait_clks(64);
    check("glitch_busy", busy, 0);
    check("glitch_valid", data_valid, 0);
    check("glitch_frame_err", frame_err, 0);

    // 0x3C with stop bit low, line then held low for 20 ticks total
    send_frame(8'h3C, 1'b0);
    check("brk_frame_err", frame_err, 1);
    check("brk_valid", data_valid, 1);
    check("brk_data_out", data_out, 8'h3C);
    wait_clks(80 - BIT_CLKS);
    check("brk_wait_busy", busy, 1);
    check("brk_no_new_byte", data_out, 8'h3C);
    check("brk_overrun", overrun, 0);
    pulse_rd();
    check("brk_rd_valid", data_valid, 0);
    check("brk_rd_frame_err", frame_err, 0);
    rx = 1'b1;
    wait_clks(8);
    check("brk_release_busy", busy, 0);
    wait_clks(BIT_CLKS);
    send_frame(8'h96, 1'b1);
    check("resume_data_out", data_out, 8'h96);
    check("resume_valid", data_valid, 1);
    check("resume_frame_err", frame_err, 0);
    pulse_rd();

    // back-to-back frames without rd
    send_frame(8'h11, 1'b1);
    check("ovr_first_overrun", overrun, 0);
    send_frame(8'h22, 1'b1);
    check("ovr_overrun", overrun, 1);
    check("ovr_data_out", data_out, 8'h22);
    check("ovr_valid", data_valid, 1);
    pulse_rd();
    check("ovr_rd_valid", data_valid, 0);
    check("ovr_rd_overrun", overrun, 0);
    pulse_rd();
    check("rd_idle_ignored", data_valid, 0);

    // mid-frame reset: hold a byte, then abort 0xFF at bit 4
    send_frame(8'h81, 1'b1);
    check("pre_rst_data_out", data_out, 8'h81);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(4 * BIT_CLKS + BIT_CLKS / 2);
    check("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("arst_data_out", data_out, 8'h00);
    check("arst_valid", data_valid, 0);
    check("arst_busy", busy, 0);
    wait_clks(3);
    rst = 1'b1;
    wait_clks(5 * BIT_CLKS);
    check("post_rst_valid", data_valid, 0);
    send_frame(8'h5A, 1'b1);
    check("post_rst_data_out", data_out, 8'h5A);
    check("post_rst_valid2", data_valid, 1);
    check("post_rst_frame_err", frame_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8x-oversampling UART receiver; sits directly downstream of the baud-rate generator and consumes its bclk_8 output.
- Deserialises the asynchronous rx line into 8-bit bytes (8N1, LSB first).
- Flags framing and overrun errors.
- Holds each byte with a valid/read handshake for the host logic.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8 supported).
- OSR, 8, sample ticks per bit; must match the generator's oversample ratio.
- MID, 4, tick index within a bit at which the line is sampled (OSR/2).

Ports:
- clk  input  1  system clock; same clock that drives the baud-rate generator.
- rst  input  1  asynchronous, active-low reset.
- bclk_8  input  1  oversample clock from the baud-rate generator, registered in the clk domain.
- rx  input  1  serial line, asynchronous, idle high.
- rd  input  1  one-clk pulse from host; consumes the held byte.
- data_out  output  DATA_BITS  last received byte.
- data_valid  output  1  high from frame completion until rd.
- frame_err  output  1  sticky; set when the stop bit is sampled 0; cleared by rd.
- overrun  output  1  sticky; set when a frame completes while data_valid=1; cleared by rd.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async):
  - State=IDLE; all counters=0.
  - data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops preset to 1 (line idle); bclk_8 edge register=0.
- rx is passed through a 2-flop synchroniser (rx_s); all decisions use rx_s.
- Tick generation:
  - tick = bclk_8 & ~bclk_8_q, where bclk_8_q is bclk_8 delayed one clk.
  - tick is exactly one clk wide, one per bclk_8 rising edge.
  - All bit timing advances only on tick.
- Tick counter tcnt: 3 bits, 0..OSR-1, wraps to 0. Bit counter bcnt: 0..DATA_BITS-1.
- State machine:
  - IDLE:
    - rx_s=0 at any clk: go to START, tcnt=0.
    - Detection is clk-resolution; timing thereafter is tick-resolution.
  - START:
    - On tick, tcnt++.
    - When tcnt reaches MID-1 on a tick, sample rx_s:
      - 0: go to DATA, tcnt=0, bcnt=0.
      - 1: glitch rejected; return to IDLE with no flags.
  - DATA:
    - On tick, tcnt++.
    - When tcnt=OSR-1 on a tick: shift rx_s into shift register MSB (LSB-first reception), tcnt=0.
    - If bcnt=DATA_BITS-1, go to STOP; else bcnt++.
  - STOP:
    - On the tick where tcnt=OSR-1, sample rx_s.
    - Then, in the same clk:
      - data_out <= shift register.
      - data_valid <= 1.
      - overrun <= overrun | data_valid(old).
      - frame_err <= frame_err | ~rx_s.
    - If rx_s=1, go to IDLE.
    - If rx_s=0 (break or framing fault), go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. No new start is accepted while the line is held low.
- Net sampling: each data bit and the stop bit are sampled at nominally mid-bit, MID+k*OSR ticks after start detection.
- Latency: data_valid rises 1 clk after the stop-bit sampling tick.
- Handshake:
  - rd while data_valid=1 clears data_valid, frame_err and overrun on the next clk.
  - rd while data_valid=0 is ignored.
  - rd in the same clk as frame completion: completion wins. data_valid stays 1 with the new byte, and overrun is not set.
- On overrun, data_out is overwritten with the newer byte.
- rst asserted mid-frame aborts immediately; a partial byte is never presented.
- bclk_8 stopped (no ticks): the FSM holds its state indefinitely; no timeout.

Test Plan:
- Reset release with rx=1 and bclk_8 toggling: all outputs 0, state IDLE, busy=0 for 200 ticks.
- Frame 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1), 8 ticks/bit:
  - data_out=0xA5, data_valid=1 after the stop-sample tick, frame_err=0.
  - rd pulse clears data_valid next clk.
- rx low glitch of 2 ticks in IDLE: returns to IDLE at mid-start sample, data_valid stays 0, no flags.
- Frame 0x3C with stop bit forced 0 and held low 20 ticks:
  - frame_err=1, data_valid=1, data_out=0x3C.
  - A second frame starting before the line rises is ignored.
  - Reception resumes after rx=1.
- Frames 0x11 then 0x22 without rd: overrun=1, data_out=0x22; rd clears data_valid and overrun.
- rst driven low at bit 4 of 0xFF: outputs go to 0 asynchronously; a following frame 0x5A is received correctly.
